// File: rtl/jzjpcc_mmio_bank.sv
// Memory-mapped I/O bank: per-channel output, direction and synchronised input
// registers, with sticky change flags gated by an enable mask into an irq.
module jzjpcc_mmio_bank #(
   parameter int          NUM_PORTS   = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'hFFFFFE00
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [29:0]               memAddress,
   input  logic                      memWriteEnable,
   input  logic [3:0]                memByteMask,
   input  logic [31:0]               memDataToWrite,
   output logic [31:0]               memDataRead,
   output logic                      hit,
   input  logic [32*NUM_PORTS-1:0]   portIn,
   output logic [32*NUM_PORTS-1:0]   portOut,
   output logic [32*NUM_PORTS-1:0]   portDir,
   output logic                      irq
);

   localparam int          PW         = 32 * NUM_PORTS;
   localparam logic [29:0] BASE_WORD  = BASE_ADDR[31:2];
   localparam logic [2:0]  PRIME_MAX  = 3'(SYNC_STAGES + 1);
   localparam logic [31:0] VALID      = (NUM_PORTS == 32) ? 32'hFFFFFFFF
                                        : 32'((64'd1 << NUM_PORTS) - 64'd1);
   localparam logic [6:0]  OFF_FLAGS  = 7'd96;
   localparam logic [6:0]  OFF_ENABLE = 7'd97;

   logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
   logic [PW-1:0]                  prev_q;
   logic [PW-1:0]                  in_val;
   logic [NUM_PORTS-1:0][31:0]     out_q;
   logic [NUM_PORTS-1:0][31:0]     dir_q;
   logic [31:0]                    flags_q;
   logic [31:0]                    enable_q;
   logic [2:0]                     prime_q;
   logic                           primed;
   logic [29:0]                    off;
   logic [6:0]                     off7;
   logic                           wr;
   logic [31:0]                    wmask;
   logic [31:0]                    changed;
   logic [31:0]                    clear;
   logic [31:0]                    flags_next;
   logic [31:0]                    rdata;

   assign off     = memAddress - BASE_WORD;
   assign off7    = off[6:0];
   assign hit     = (off < 30'd128);
   assign wr      = memWriteEnable & hit;
   assign wmask   = {{8{memByteMask[3]}}, {8{memByteMask[2]}},
                     {8{memByteMask[1]}}, {8{memByteMask[0]}}};
   assign in_val  = sync_q[SYNC_STAGES-1];
   assign primed  = (prime_q == PRIME_MAX);
   assign portOut = out_q;
   assign portDir = dir_q;

   // A fresh change always beats a same-cycle W1C so no event is lost.
   always_comb begin
      changed = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         changed[i] = (in_val[32*i +: 32] != prev_q[32*i +: 32]);
      clear = '0;
      if (wr && off7 == OFF_FLAGS)
         clear = memDataToWrite & wmask & VALID;
      flags_next = (flags_q & ~clear) | (primed ? changed : 32'd0);
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (off7 == 7'(i))      rdata = out_q[i];
         if (off7 == 7'(32 + i)) rdata = in_val[32*i +: 32];
         if (off7 == 7'(64 + i)) rdata = dir_q[i];
      end
      if (off7 == OFF_FLAGS)  rdata = flags_q;
      if (off7 == OFF_ENABLE) rdata = enable_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q      <= '0;
         prev_q      <= '0;
         out_q       <= '0;
         dir_q       <= '0;
         flags_q     <= '0;
         enable_q    <= '0;
         prime_q     <= '0;
         memDataRead <= '0;
         irq         <= 1'b0;
      end else begin
         sync_q[0] <= portIn;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync_q[s] <= sync_q[s-1];
         prev_q <= in_val;
         if (!primed)
            prime_q <= prime_q + 3'd1;
         flags_q     <= flags_next;
         irq         <= |(flags_q & enable_q);
         memDataRead <= hit ? rdata : 32'd0;
         if (wr) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (off7 == 7'(i))
                  out_q[i] <= (out_q[i] & ~wmask) | (memDataToWrite & wmask);
               if (off7 == 7'(64 + i))
                  dir_q[i] <= (dir_q[i] & ~wmask) | (memDataToWrite & wmask);
            end
            if (off7 == OFF_ENABLE)
               enable_q <= ((enable_q & ~wmask) | (memDataToWrite & wmask)) & VALID;
         end
      end
   end

endmodule

// File: doc/jzjpcc_mmio_bank.md
Name: jzjpcc_mmio_bank

Overview:
Parametrised memory-mapped I/O bank for the jzjpcc core. It replaces the fixed 8-in/8-out word ports with a configurable number of channels. Each channel has an input synchroniser, an output register, a direction register, and sticky change-detect flags that drive an interrupt request. It sits beside the memory backend and decodes execute-stage memory accesses that fall in its address window. Read data is returned in the memory stage.

Parameters:
NUM_PORTS, 8, number of channels; legal range 1..32.
SYNC_STAGES, 2, flip-flop depth of each input synchroniser; legal range 2..4.
BASE_ADDR, 32'hFFFFFE00, byte address of the window; word aligned; window is 128 words.

Ports:
clock  input  1  core clock.
reset  input  1  synchronous, active-high.
memAddress  input  30  word address [31:2], from execute stage.
memWriteEnable  input  1  store strobe, one cycle.
memByteMask  input  4  byte enables for the store.
memDataToWrite  input  32  store data.
memDataRead  output  32  registered read data; valid in the cycle after the address is presented.
hit  output  1  combinational; address lies inside the window.
portIn  input  32xNUM_PORTS  raw asynchronous channel inputs.
portOut  output  32xNUM_PORTS  output registers.
portDir  output  32xNUM_PORTS  per-bit direction; 1 = drive.
irq  output  1  registered interrupt request.

Behaviour:
- Word offset: off = memAddress - BASE_ADDR[31:2]; hit = 1 when off < 128.
- Address map by word offset:
  - i (i < N): OUT[i], read/write.
  - 32+i: IN[i], read-only; returns the synchronised value.
  - 64+i: DIR[i], read/write.
  - 96: FLAGS, bit i set = channel i changed; write-1-to-clear.
  - 97: ENABLE, interrupt mask; read/write; bits >= N read 0 and ignore writes.
  - Every other offset in the window: reads 0, writes ignored.
- Stores take effect only when memWriteEnable && hit. Each byte lane is updated only if its memByteMask bit is set. For FLAGS, a 1 in an enabled lane clears that bit.
- Read path is one-cycle registered: memDataRead(t+1) = reg(memAddress(t)). A read in the same cycle as a write to the same register returns the old value.
- When hit = 0 in cycle t, memDataRead(t+1) = 0 so the top level can OR-merge it with RAM data.
- Synchroniser: SYNC_STAGES flops per bit. IN[i] is the last stage. A previous-value register holds the last stage delayed by one clock.
- Change detect: FLAGS[i] sets when IN[i] != prev[i] and the bank is primed.
- Set/clear priority: when a set and a W1C clear hit the same bit in the same cycle, set wins.
- Priming counter: after reset it counts SYNC_STAGES+1 clocks. Flags cannot set until it saturates. This suppresses the false change caused by the synchroniser filling with zeros.
- irq(t+1) = |(FLAGS(t) & ENABLE(t)).
- Reset: every register returns to 0 on a reset-high clock edge, including a reset asserted mid-transaction. Affected: OUT, DIR, FLAGS, ENABLE, synchroniser and prev flops, priming counter, memDataRead, irq. A store coincident with reset is discarded.
- Channels at or above NUM_PORTS do not exist. Their OUT, IN and DIR offsets read 0.

Test Plan:
1. Reset with portIn[0] = 32'hA5A5A5A5, wait 10 clocks -> FLAGS = 0, irq = 0, read of IN[0] at 0xFFFFFE80 returns 32'hA5A5A5A5 one cycle after the address.
2. Store 32'h12345678 to OUT[3] with mask 4'b0011 after OUT[3] = 32'hFFFFFFFF -> portOut[3] = 32'hFFFF5678 on the next edge; readback at 0xFFFFFE0C returns the same value.
3. ENABLE = 1<<2, toggle portIn[2] from 0 to 1 -> FLAGS bit 2 set SYNC_STAGES+1 clocks after the toggle, irq high one clock later; W1C 32'h4 to FLAGS -> irq low the following cycle.
4. W1C of FLAGS bit 2 in the same cycle a new change on channel 2 is detected -> bit 2 remains 1.
5. Read 0x00001000 (miss) and 0xFFFFFFF0 (unmapped in-window offset) -> hit = 0 / 1 respectively, memDataRead = 0 for both.
6. Assert reset during a store to DIR[1] = 32'hFFFF0000 -> portDir[1] = 0, memDataRead = 0 and irq = 0 after the edge.
